// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master arbiter in front of a single-port synchronous RAM. Master 0 is the
// CPU, master 1 is the DMA engine. Each transfer takes exactly three cycles:
// IDLE (arbitrate and launch), ACCESS (RAM strobe), DONE (ready pulse).
// Simultaneous requests are resolved round-robin. After reset, master 0 is
// preferred.
//
// Parameters
//   RAM_AW        word-address width of the RAM (2**RAM_AW 32-bit words)
//
// Ports
//   sys_clk       clock; all state changes on its rising edge
//   sys_resetn    asynchronous active-low reset
//   mX_valid      request from master X; held with addr/wdata/wstrb until ready
//   mX_addr       byte address
//   mX_wdata      write data
//   mX_wstrb      byte strobes; nonzero = write, zero = read
//   mX_ready      one-cycle completion pulse to master X
//   m_rdata       read data, valid while a ready is high; zero otherwise
//   ram_address   registered RAM word address
//   ram_byteena   registered RAM byte enables
//   ram_data      registered RAM write data
//   ram_rden      registered RAM read enable (high only in ACCESS)
//   ram_wren      registered RAM write enable (high only in ACCESS)
//   ram_q         RAM read data, valid one cycle after ram_rden
//   bus_err       one-cycle pulse, aligned with ready, on out-of-range access
//   grant         one-hot owner of the current transfer; 00 when idle
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int RAM_AW = 8
) (
    input  logic              sys_clk,
    input  logic              sys_resetn,

    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,

    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,

    output logic [31:0]       m_rdata,

    output logic [RAM_AW-1:0] ram_address,
    output logic [3:0]        ram_byteena,
    output logic [31:0]       ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,

    output logic              bus_err,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Control state
    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_m1_q, last_m1_d;   // 1: master 1 was granted last
    logic              err_q, err_d;           // current transfer is out of range
    logic              rd_q, rd_d;             // current transfer is an in-range read
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;

    // RAM-side datapath registers (no reset needed: qualified by rden/wren)
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       data_q, data_d;

    // Winner selection: m1 wins if it is the sole requester, or if both
    // request and m0 was the last one served.
    logic              pick_m1;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;
    logic              sel_inrange;
    logic              sel_write;

    always_comb begin
        pick_m1     = m1_valid && (!m0_valid || !last_m1_q);
        sel_addr    = pick_m1 ? m1_addr  : m0_addr;
        sel_wdata   = pick_m1 ? m1_wdata : m0_wdata;
        sel_wstrb   = pick_m1 ? m1_wstrb : m0_wstrb;
        sel_inrange = (sel_addr[31:RAM_AW+2] == '0);
        sel_write   = (sel_wstrb != 4'b0000);
    end

    // Byte-lane bits of the address are meaningless for a word-wide RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, sel_addr[1:0]};

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_m1_d = last_m1_q;
        err_d     = err_q;
        rd_d      = rd_q;
        rden_d    = 1'b0;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        be_d      = be_q;
        data_d    = data_q;

        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d   = ACCESS;
                    grant_d   = pick_m1 ? 2'b10 : 2'b01;
                    last_m1_d = pick_m1;
                    err_d     = !sel_inrange;
                    rd_d      = sel_inrange && !sel_write;
                    // RAM strobes are registered here so they are high
                    // exactly during the ACCESS cycle.
                    rden_d    = sel_inrange && !sel_write;
                    wren_d    = sel_inrange &&  sel_write;
                    addr_d    = sel_addr[RAM_AW+1:2];
                    be_d      = sel_wstrb;
                    data_d    = sel_wdata;
                end
            end
            ACCESS: begin
                // Transfer is committed; a dropped valid does not abort it.
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
                err_d   = 1'b0;
                rd_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                err_d   = 1'b0;
                rd_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_m1_q <= 1'b1;      // makes m0 the preferred master after reset
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_m1_q <= last_m1_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        addr_q <= addr_d;
        be_q   <= be_d;
        data_q <= data_d;
    end

    // Outputs: everything master-facing is decoded from registered state, so
    // an asynchronous reset clears it immediately.
    logic in_done;

    always_comb begin
        in_done     = (state_q == DONE);
        grant       = grant_q;
        m0_ready    = in_done && grant_q[0];
        m1_ready    = in_done && grant_q[1];
        bus_err     = in_done && err_q;
        m_rdata     = (in_done && rd_q) ? ram_q : 32'h0000_0000;
        ram_address = addr_q;
        ram_byteena = be_q;
        ram_data    = data_q;
        ram_rden    = rden_q;
        ram_wren    = wren_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. A transaction-level model (timestamps,
// queue-free single-outstanding transfer, word array) predicts every output on
// every falling edge; directed tests additionally pin literal values.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int RAM_AW = 8;
    localparam int WORDS  = 1 << RAM_AW;

    logic              sys_clk    = 1'b0;
    logic              sys_resetn = 1'b0;

    logic              m0_valid = 1'b0;
    logic [31:0]       m0_addr  = '0;
    logic [31:0]       m0_wdata = '0;
    logic [3:0]        m0_wstrb = '0;
    logic              m0_ready;
    logic              m1_valid = 1'b0;
    logic [31:0]       m1_addr  = '0;
    logic [31:0]       m1_wdata = '0;
    logic [3:0]        m1_wstrb = '0;
    logic              m1_ready;
    logic [31:0]       m_rdata;
    logic [RAM_AW-1:0] ram_address;
    logic [3:0]        ram_byteena;
    logic [31:0]       ram_data;
    logic              ram_rden;
    logic              ram_wren;
    logic [31:0]       ram_q = '0;
    logic              bus_err;
    logic [1:0]        grant;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.RAM_AW(RAM_AW)) dut (
        .sys_clk     (sys_clk),
        .sys_resetn  (sys_resetn),
        .m0_valid    (m0_valid),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m1_valid    (m1_valid),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m_rdata     (m_rdata),
        .ram_address (ram_address),
        .ram_byteena (ram_byteena),
        .ram_data    (ram_data),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .bus_err     (bus_err),
        .grant       (grant)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- RAM attached to the DUT ----------------
    logic [31:0] ram [WORDS];

    always @(posedge sys_clk) begin
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteena[b]) ram[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
        if (ram_rden) ram_q <= ram[ram_address];
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem [WORDS];
    bit          act     = 1'b0;   // a transfer is in flight
    bit          last_m1 = 1'b1;   // m0 preferred after reset
    int          ecnt    = 0;      // rising edges seen out of reset
    int          acc     = 0;      // edge at which the transfer was accepted
    int          t_m     = 0;
    logic [31:0] t_addr, t_wd, t_rd;
    logic [3:0]  t_ws;

    function automatic bit in_range(input logic [31:0] a);
        return (a >> (RAM_AW + 2)) == 0;
    endfunction

    always @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            act     = 1'b0;
            last_m1 = 1'b1;
        end else begin
            ecnt++;
            if (act && ecnt == acc + 1) begin
                t_rd = 32'h0;
                if (in_range(t_addr)) begin
                    if (t_ws != 0) begin
                        for (int b = 0; b < 4; b++)
                            if (t_ws[b]) mdl_mem[t_addr[RAM_AW+1:2]][8*b +: 8] = t_wd[8*b +: 8];
                    end else begin
                        t_rd = mdl_mem[t_addr[RAM_AW+1:2]];
                    end
                end
            end
            if (act && ecnt == acc + 2) begin
                act = 1'b0;
            end else if (!act && (m0_valid || m1_valid)) begin
                if (m0_valid && m1_valid) t_m = last_m1 ? 0 : 1;
                else                      t_m = m0_valid ? 0 : 1;
                last_m1 = (t_m == 1);
                t_addr  = t_m ? m1_addr  : m0_addr;
                t_wd    = t_m ? m1_wdata : m0_wdata;
                t_ws    = t_m ? m1_wstrb : m0_wstrb;
                t_rd    = 32'h0;
                act     = 1'b1;
                acc     = ecnt;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge sys_clk) begin
        logic [1:0]  e_grant;
        logic        e_r0, e_r1, e_err, e_rden, e_wren, chk_ram, inr, wr;
        logic [31:0] e_rd;
        e_grant = 2'b00; e_r0 = 0; e_r1 = 0; e_err = 0; e_rden = 0; e_wren = 0;
        chk_ram = 0; e_rd = 32'h0; inr = 0; wr = 0;
        if (sys_resetn && act) begin
            inr = in_range(t_addr);
            wr  = (t_ws != 0);
            if (ecnt == acc) begin
                e_grant = t_m ? 2'b10 : 2'b01;
                e_rden  = inr && !wr;
                e_wren  = inr && wr;
                chk_ram = inr;
            end else if (ecnt == acc + 1) begin
                e_grant = t_m ? 2'b10 : 2'b01;
                e_r0    = (t_m == 0);
                e_r1    = (t_m == 1);
                e_rd    = (inr && !wr) ? t_rd : 32'h0;
                e_err   = !inr;
            end
        end
        check("grant",    grant,    e_grant);
        check("m0_ready", m0_ready, e_r0);
        check("m1_ready", m1_ready, e_r1);
        check("m_rdata",  m_rdata,  e_rd);
        check("bus_err",  bus_err,  e_err);
        check("ram_rden", ram_rden, e_rden);
        check("ram_wren", ram_wren, e_wren);
        if (chk_ram) begin
            check("ram_address", ram_address, t_addr[RAM_AW+1:2]);
            check("ram_byteena", ram_byteena, t_ws);
            check("ram_data",    ram_data,    t_wd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end
    endtask

    // Uncontended transfer: returns what was seen in the ACCESS cycle and at
    // ready, plus the ready latency in cycles after the sampling edge.
    task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws,
                        output logic a_rden, output logic a_wren,
                        output logic [31:0] a_addr, output logic [3:0] a_be,
                        output logic [31:0] rd, output logic er, output int lat);
        a_rden = 0; a_wren = 0; a_addr = 0; a_be = 0; rd = 0; er = 0; lat = 0;
        drive(m, 1'b1, a, wd, ws);
        @(posedge sys_clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge sys_clk);
            if (i == 1) begin
                a_rden = ram_rden; a_wren = ram_wren;
                a_addr = 32'(ram_address); a_be = ram_byteena;
            end
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
                lat = i; rd = m_rdata; er = bus_err;
                break;
            end
        end
        if (lat == 0) check("xfer_timeout", 0, 1);
        @(posedge sys_clk); #2;
        drive(m, 1'b0, a, wd, ws);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic        rr, ww, er;
        logic [31:0] aa, rd;
        logic [3:0]  be;
        int          lat;
        int          who [4];
        int          when [4];
        int          nev;
        bit          got;

        for (int i = 0; i < WORDS; i++) begin
            ram[i]     = 32'h5A00_0000 | 32'(i);
            mdl_mem[i] = 32'h5A00_0000 | 32'(i);
        end
        ram[4] = 32'hDEAD_BEEF;  mdl_mem[4] = 32'hDEAD_BEEF;
        ram[2] = 32'hAABB_CCDD;  mdl_mem[2] = 32'hAABB_CCDD;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #2;
        check("rst_grant", grant, 2'b00);
        check("rst_ready", {m0_ready, m1_ready}, 2'b00);
        check("rst_strobes", {ram_rden, ram_wren, bus_err}, 3'b000);
        check("rst_rdata", m_rdata, 32'h0);
        sys_resetn = 1'b1;
        @(posedge sys_clk); #2;

        // m0 read of word 4
        xfer(0, 32'h0000_0010, 32'h0, 4'h0, rr, ww, aa, be, rd, er, lat);
        check("rd_access_rden", rr, 1'b1);
        check("rd_access_addr", aa, 32'd4);
        check("rd_latency", lat, 2);
        check("rd_data", rd, 32'hDEAD_BEEF);

        // m0 out-of-range read
        xfer(0, 32'h0000_8000, 32'h0, 4'h0, rr, ww, aa, be, rd, er, lat);
        check("oor_strobes", {rr, ww}, 2'b00);
        check("oor_latency", lat, 2);
        check("oor_rdata", rd, 32'h0);
        check("oor_err", er, 1'b1);

        // m0 write with valid dropped during ACCESS
        drive(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
        @(posedge sys_clk); #2;
        drive(0, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
        @(negedge sys_clk);
        check("drop_wren", ram_wren, 1'b1);
        @(negedge sys_clk);
        check("drop_ready", m0_ready, 1'b1);
        @(negedge sys_clk);
        check("drop_ready_once", m0_ready, 1'b0);
        @(posedge sys_clk); #2;
        xfer(0, 32'h0000_0020, 32'h0, 4'h0, rr, ww, aa, be, rd, er, lat);
        check("drop_readback", rd, 32'hCAFE_F00D);

        // m1 byte write to word 2
        xfer(1, 32'h0000_0008, 32'h1122_3344, 4'b0001, rr, ww, aa, be, rd, er, lat);
        check("wr_access_wren", {rr, ww}, 2'b01);
        check("wr_access_be", be, 4'b0001);
        check("wr_access_addr", aa, 32'd2);
        check("wr_latency", lat, 2);

        // Both masters request continuously: m1 went last, so m0 leads
        drive(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0000_0008, 32'h0, 4'h0);
        nev = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge sys_clk);
            if ((m0_ready || m1_ready) && nev < 4) begin
                who[nev]  = m1_ready ? 1 : 0;
                when[nev] = i;
                if (m1_ready) check("alt_m1_rdata", m_rdata, 32'hAABB_CC44);
                nev++;
            end
        end
        @(posedge sys_clk); #2;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("alt_count", nev, 4);
        for (int k = 0; k < nev; k++) begin
            check("alt_master", who[k], k % 2);
            check("alt_cycle", when[k], 3 + 3 * k);
        end
        repeat (2) @(posedge sys_clk);
        #2;

        // Reset during ACCESS of a write
        drive(0, 1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF);
        @(posedge sys_clk); #3;
        check("rstacc_pre_wren", ram_wren, 1'b1);
        sys_resetn = 1'b0;
        #1;
        check("rstacc_wren", ram_wren, 1'b0);
        check("rstacc_grant", grant, 2'b00);
        check("rstacc_ready", {m0_ready, m1_ready}, 2'b00);
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge sys_clk);
        #2;
        sys_resetn = 1'b1;
        drive(0, 1'b1, 32'h0000_0030, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
        got = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge sys_clk);
            if (m0_ready || m1_ready) begin
                got = 1;
                check("rstacc_first_m0", m0_ready, 1'b1);
                check("rstacc_no_commit", m_rdata, 32'h5A00_000C);
            end
        end
        if (!got) check("rstacc_timeout", 0, 1);
        @(posedge sys_clk); #2;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        got = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge sys_clk);
            if (m1_ready) begin
                got = 1;
                check("rstacc_m1_rdata", m_rdata, 32'hDEAD_BEEF);
            end
        end
        if (!got) check("rstacc_m1_timeout", 0, 1);
        @(posedge sys_clk); #2;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge sys_clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, word-address width of the shared RAM (2^RAM_AW 32-bit words).
REQ-002 SHALL have port sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports m0_valid/m1_valid  input  1  request from master 0 (CPU) / master 1 (DMA); held with address and data until ready.
REQ-005 SHALL have ports m0_addr/m1_addr  input  32  byte address.
REQ-006 SHALL have ports m0_wdata/m1_wdata  input  32  write data.
REQ-007 SHALL have ports m0_wstrb/m1_wstrb  input  4  byte strobes; nonzero = write, zero = read.
REQ-008 SHALL have ports m0_ready/m1_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have port m_rdata  output  32  read data, valid while a ready is high.
REQ-010 SHALL have ports ram_address (RAM_AW), ram_byteena (4), ram_data (32), ram_rden (1), ram_wren (1)  output  drive to RAM with registered output.
REQ-011 SHALL have port ram_q  input  32  RAM read data, one cycle after rden.
REQ-012 SHALL have port bus_err  output  1  one-cycle pulse on out-of-range access.
REQ-013 SHALL have port grant  output  2  one-hot owner of the current transfer; 00 when idle.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 IDLE: if any valid is high, the arbiter SHALL latch the winner into grant and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration: sole requester wins; if both request, the master not granted last wins (round-robin); after reset m0 has priority.
REQ-017 ACCESS (exactly 1 cycle): ram_address = granted addr[RAM_AW+1:2], ram_byteena = granted wstrb, ram_data = granted wdata; ram_wren = 1 if wstrb != 0, else ram_rden = 1; then go to DONE.
REQ-018 In-range SHALL mean addr[31:RAM_AW+2] == 0; out of range SHALL assert neither rden nor wren and SHALL set an internal error flag.
REQ-019 DONE (exactly 1 cycle): the granted master's ready SHALL be high; m_rdata = ram_q for an in-range read, 0 otherwise; bus_err = error flag; then go to IDLE with grant = 00.
REQ-020 Latency: valid sampled in IDLE at edge N -> ACCESS during cycle N+1 -> ready during cycle N+2; maximum throughput one transfer per 3 cycles.
REQ-021 Only one of m0_ready, m1_ready SHALL be high at any time, and never for the non-granted master.
REQ-022 ram_rden and ram_wren SHALL be 0 outside ACCESS and SHALL never both be 1.
REQ-023 A deasserted valid during ACCESS/DONE SHALL NOT abort the transfer; the write commits and ready still pulses.
REQ-024 A request arriving while busy SHALL wait; it SHALL be served in the next IDLE, giving worst-case wait 3 cycles per competing transfer.
REQ-025 m_rdata SHALL be 0 outside DONE.

Reset
REQ-026 While sys_resetn = 0, the FSM SHALL be in IDLE, grant = 00, ready, rden, wren and bus_err = 0, m_rdata = 0, and round-robin pointer = m0 preferred.
REQ-027 Reset asserted in ACCESS or DONE SHALL drop all outputs immediately; the interrupted transfer SHALL produce no ready.

Verification
REQ-028 m0 read addr 0x0000_0010, RAM word 4 = 0xDEADBEEF -> rden with address 4 at cycle N+1; m0_ready with m_rdata 0xDEADBEEF at N+2.
REQ-029 m1 write addr 0x8, wdata 0x11223344, wstrb 0001 -> wren, byteena 0001, address 2; m1_ready at N+2; readback of word 2 has byte0 = 0x44.
REQ-030 m0 and m1 request continuously -> grants alternate m0, m1, m0, m1; each ready 3 cycles apart.
REQ-031 m0 read addr 0x0000_8000 -> no rden/wren; m0_ready with m_rdata 0 and bus_err = 1 in the same cycle.
REQ-032 sys_resetn pulsed low during ACCESS of a write -> outputs go to 0 asynchronously; no ready; the first request after release is granted to m0 if both request.
REQ-033 m0 valid dropped in ACCESS -> the write still commits and m0_ready still pulses once.
